// File: rtl/bep_frame_pkg.sv
// Shared frame map and sequencer state type for the BEP thermostat receive path.
package bep_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam int          FRAME_BITS    = 192;
  localparam logic [31:0] PREAMBLE_WORD = 32'h5555_5555;

  // Field offsets count from the first bit received (MSB first on the wire).
  localparam int OFF_PREAMBLE = 0;    localparam int W_PREAMBLE = 32;
  localparam int OFF_TYPE_A   = 32;   localparam int W_TYPE_A   = 16;
  localparam int OFF_TYPE_B   = 48;   localparam int W_TYPE_B   = 16;
  localparam int OFF_CONST    = 64;   localparam int W_CONST    = 32;
  localparam int OFF_ID       = 96;   localparam int W_ID       = 32;
  localparam int OFF_ROOM     = 128;  localparam int W_ROOM     = 16;
  localparam int OFF_SET      = 144;  localparam int W_SET      = 16;
  localparam int OFF_STATE    = 160;  localparam int W_STATE    = 8;
  localparam int OFF_TAIL     = 168;  localparam int W_TAIL     = 24;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bep_gap_timer.sv
// Line-idle timer: cleared by every bit strobe, flags the cycle in which it reaches GAP_CYCLES-1.
module bep_gap_timer #(
  parameter int GAP_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic expire_o
);

  localparam int            CW   = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] PREV = CW'(GAP_CYCLES - 2);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (count_q != LAST) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Asserted while the counter steps onto LAST, so the owner can act on the same edge.
  assign expire_o = !clear_i && (count_q == PREV);

endmodule

// File: rtl/bep_frame_sequencer.sv
// Gates recovered bits into the field shift register, ends frames on line idle, holds good frames for ack.
// Optional statistics counters (err_count, drop_count) are built only when SEQ_STATS_EN is defined.
module bep_frame_sequencer #(
  parameter int          FRAME_BITS    = bep_frame_pkg::FRAME_BITS,
  parameter logic [31:0] PREAMBLE_WORD = bep_frame_pkg::PREAMBLE_WORD,
  parameter int          GAP_CYCLES    = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_strobe,
  input  logic       bit_data,
  input  logic       frame_ack,
  output logic       shift_strobe,
  output logic       decoder_clear,
  output logic       frame_valid,
  output logic       frame_error,
  output logic [7:0] bit_count,
  output logic [7:0] err_count,
  output logic [7:0] drop_count
);

  import bep_frame_pkg::*;

  localparam logic [7:0] FRAME_LEN = 8'(FRAME_BITS);

  seq_state_e state_q, state_d;
  logic [7:0] bit_count_q, bit_count_d;
  logic       pre_bad_q, pre_bad_d;
  logic       over_q, over_d;
  logic       valid_q, valid_d;
  logic       clr_q, clr_d;
  logic       ferr_q, ferr_d;
  logic       err_inc, drop_inc;
  logic       gap_expire;
  logic       pre_miss;

  bep_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (bit_strobe),
    .expire_o(gap_expire)
  );

  // Inverting the low five count bits yields 31-bit_count while inside the preamble.
  assign pre_miss = (bit_count_q < 8'd32) && (bit_data != PREAMBLE_WORD[~bit_count_q[4:0]]);

  assign shift_strobe = bit_strobe &&
                        ((state_q == ST_IDLE) || ((state_q == ST_RECV) && (bit_count_q < FRAME_LEN)));

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    pre_bad_d   = pre_bad_q;
    over_d      = over_q;
    valid_d     = valid_q;
    clr_d       = clr_q;
    ferr_d      = 1'b0;
    err_inc     = 1'b0;
    drop_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_count_d = '0;
        pre_bad_d   = 1'b0;
        over_d      = 1'b0;
        valid_d     = 1'b0;
        clr_d       = 1'b1;
        if (bit_strobe) begin
          state_d     = ST_RECV;
          bit_count_d = 8'd1;
          pre_bad_d   = pre_miss;
          clr_d       = 1'b0;
        end
      end
      ST_RECV: begin
        if (bit_strobe) begin
          if (bit_count_q < FRAME_LEN) bit_count_d = bit_count_q + 8'd1;
          else                         over_d      = 1'b1;
          if (pre_miss) pre_bad_d = 1'b1;
        end else if (gap_expire) begin
          if ((bit_count_q == FRAME_LEN) && !pre_bad_q && !over_q) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            ferr_d      = 1'b1;
            err_inc     = 1'b1;
            clr_d       = 1'b1;
            bit_count_d = '0;
          end
        end
      end
      ST_DONE: begin
        drop_inc = bit_strobe;
        if (frame_ack) begin
          state_d     = ST_IDLE;
          valid_d     = 1'b0;
          clr_d       = 1'b1;
          bit_count_d = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        valid_d     = 1'b0;
        clr_d       = 1'b1;
        bit_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_count_q <= '0;
      pre_bad_q   <= 1'b0;
      over_q      <= 1'b0;
      valid_q     <= 1'b0;
      clr_q       <= 1'b1;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      pre_bad_q   <= pre_bad_d;
      over_q      <= over_d;
      valid_q     <= valid_d;
      clr_q       <= clr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign decoder_clear = clr_q;
  assign frame_valid   = valid_q;
  assign frame_error   = ferr_q;
  assign bit_count     = bit_count_q;

`ifdef SEQ_STATS_EN
  logic [7:0] err_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (err_inc)  err_cnt_q  <= sat_inc8(err_cnt_q);
      if (drop_inc) drop_cnt_q <= sat_inc8(drop_cnt_q);
    end
  end

  assign err_count  = err_cnt_q;
  assign drop_count = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = err_inc | drop_inc;
  assign err_count    = '0;
  assign drop_count   = '0;
`endif

endmodule

// File: tb/tb_bep_frame_sequencer.sv
// Directed, table-driven bench for bep_frame_sequencer with a 16-cycle idle gap.
module tb_bep_frame_sequencer;

  localparam int          GAP  = 16;
  localparam logic [31:0] PRE  = 32'h5555_5555;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_strobe = 1'b0;
  logic       bit_data = 1'b0;
  logic       frame_ack = 1'b0;
  logic       shift_strobe, decoder_clear, frame_valid, frame_error;
  logic [7:0] bit_count, err_count, drop_count;

  bep_frame_sequencer #(
    .FRAME_BITS   (192),
    .PREAMBLE_WORD(PRE),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_strobe   (bit_strobe),
    .bit_data     (bit_data),
    .frame_ack    (frame_ack),
    .shift_strobe (shift_strobe),
    .decoder_clear(decoder_clear),
    .frame_valid  (frame_valid),
    .frame_error  (frame_error),
    .bit_count    (bit_count),
    .err_count    (err_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    nbits;
    int    flip;
    int    gap_at;
    int    gap_len;
    int    exp_valid;
    int    exp_shifts;
    int    exp_bc;
    int    exp_errs;
    int    hold;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int shifts = 0;
  int errs_seen = 0;
  int exp_err = 0;
  int exp_drop = 0;

  always @(negedge clk) begin
    if (shift_strobe) shifts <= shifts + 1;
    if (frame_error)  errs_seen <= errs_seen + 1;
  end

  function automatic int stat(input int v);
`ifdef SEQ_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    bit_strobe = 1'b1;
    bit_data   = b;
    @(posedge clk);
    #1;
    bit_strobe = 1'b0;
  endtask

  function automatic logic frame_bit(input int i);
    logic [31:0] p;
    p = PRE;
    if (i < 32) return p[31-i];
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic run_frame(input vec_t v);
    logic b;
    int   s0;
    shifts    = 0;
    errs_seen = 0;
    idle(1);
    for (int i = 0; i < v.nbits; i++) begin
      b = frame_bit(i);
      if (i == v.flip) b = ~b;
      send_bit(b);
      if (i != v.nbits - 1) idle((i == v.gap_at) ? v.gap_len - 1 : 3);
    end
    idle(GAP - 2);
    @(negedge clk);
    chk({v.name, " bit_count"}, int'(bit_count), v.exp_bc);
    chk({v.name, " valid early"}, int'(frame_valid), 0);
    idle(1);
    @(negedge clk);
    chk({v.name, " valid at gap"}, int'(frame_valid), v.exp_valid);
    idle(1);
    @(negedge clk);
    chk({v.name, " error pulse width"}, int'(frame_error), 0);
    idle(1);
    exp_err += v.exp_errs;
    chk({v.name, " error pulses"}, errs_seen, v.exp_errs);
    chk({v.name, " shifts"}, shifts, v.exp_shifts);
    chk({v.name, " err_count"}, int'(err_count), stat(exp_err));
    if (v.exp_valid != 0) begin
      s0 = shifts;
      for (int k = 0; k < v.hold; k++) begin
        send_bit(1'b1);
        idle(3);
      end
      exp_drop += v.hold;
      chk({v.name, " hold shifts"}, shifts, s0);
      chk({v.name, " hold valid"}, int'(frame_valid), 1);
      chk({v.name, " drop_count"}, int'(drop_count), stat(exp_drop));
      frame_ack = 1'b1;
      idle(1);
      frame_ack = 1'b0;
      @(negedge clk);
      chk({v.name, " valid after ack"}, int'(frame_valid), 0);
      chk({v.name, " clear after ack"}, int'(decoder_clear), 1);
      idle(1);
    end else begin
      chk({v.name, " clear after error"}, int'(decoder_clear), 1);
    end
  endtask

  vec_t tbl[6];
  vec_t good;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    //          name          nbits flip gap_at gap_len valid shifts bc  errs hold
    tbl[0] = '{"good",        192,  -1,  -1,    0,      1,    192,   192, 0,   10};
    tbl[1] = '{"bad_pre",     192,   5,  -1,    0,      0,    192,   192, 1,   0};
    tbl[2] = '{"short191",    191,  -1,  -1,    0,      0,    191,   191, 1,   0};
    tbl[3] = '{"long195",     195,  -1,  -1,    0,      0,    192,   192, 1,   0};
    tbl[4] = '{"gap15",       192,  -1,  100,   15,     1,    192,   192, 0,   0};
    tbl[5] = '{"gap16",       192,  -1,  100,   16,     0,    192,   91,  2,   0};
    good   = '{"after_reset", 192,  -1,  -1,    0,      1,    192,   192, 0,   0};

    idle(3);
    @(negedge clk);
    chk("reset shift_strobe", int'(shift_strobe), 0);
    chk("reset decoder_clear", int'(decoder_clear), 1);
    chk("reset frame_valid", int'(frame_valid), 0);
    chk("reset frame_error", int'(frame_error), 0);
    chk("reset bit_count", int'(bit_count), 0);
    chk("reset err_count", int'(err_count), 0);
    chk("reset drop_count", int'(drop_count), 0);
    idle(1);
    rst_n = 1'b1;
    idle(2);

    for (int t = 0; t < 6; t++) run_frame(tbl[t]);

    // Reset in the middle of a frame, then a clean frame must still decode.
    for (int i = 0; i < 100; i++) begin
      send_bit(frame_bit(i));
      idle(3);
    end
    chk("mid-frame bit_count", int'(bit_count), 100);
    rst_n = 1'b0;
    #1;
    chk("async reset bit_count", int'(bit_count), 0);
    chk("async reset decoder_clear", int'(decoder_clear), 1);
    chk("async reset err_count", int'(err_count), 0);
    idle(1);
    rst_n = 1'b1;
    exp_err  = 0;
    exp_drop = 0;
    idle(2);
    run_frame(good);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
